// File: rtl/sseg_scan_driver.sv
// Time-multiplexed scan driver for a multi-digit 7-segment display.
// Double-buffered digit codes, leading-zero blanking and an anti-ghosting guard at the start of each dwell.
module sseg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_blank,
    output logic [3:0]            hex,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  dp,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] RST_SEL  = (GUARD > 0) ? '0 : DIGITS'(1);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] act_val;
    logic [DIGITS-1:0]   act_dp;
    logic [4*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]   pend_dp;

    logic                tick;
    logic                boundary;
    logic                swap;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [IDX_W-1:0]    idx_nxt;
    logic [4*DIGITS-1:0] act_val_nxt;
    logic [DIGITS-1:0]   act_dp_nxt;
    logic [DIGITS-1:0]   blank;
    logic                zero_run;
    logic [3:0]          hex_nxt;
    logic                dp_nxt;
    logic [DIGITS-1:0]   sel_nxt;

    always_comb begin
        tick        = (cnt == CNT_LAST);
        boundary    = tick && (idx == IDX_LAST);
        cnt_nxt     = tick ? '0 : cnt + 1'b1;
        idx_nxt     = idx;
        if (tick)
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        act_val_nxt = act_val;
        act_dp_nxt  = act_dp;
        swap        = 1'b0;
        // A load on the boundary itself bypasses the pending buffer.
        if (boundary) begin
            if (load) begin
                act_val_nxt = value;
                act_dp_nxt  = dp_in;
                swap        = 1'b1;
            end else if (pending) begin
                act_val_nxt = pend_val;
                act_dp_nxt  = pend_dp;
                swap        = 1'b1;
            end
        end
    end

    // Outputs are computed from next-state values so they change exactly one clock after tick.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            zero_run = zero_run && (act_val_nxt[4*j +: 4] == 4'h0);
            if (j > 0)
                blank[j] = zero_run;
        end
        hex_nxt = act_val_nxt[4*idx_nxt +: 4];
        if (lz_blank && blank[idx_nxt])
            hex_nxt = 4'hF;
        dp_nxt  = act_dp_nxt[idx_nxt];
        sel_nxt = (int'(cnt_nxt) < GUARD) ? '0 : (DIGITS'(1) << idx_nxt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            act_val    <= {DIGITS{4'hF}};
            act_dp     <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            hex        <= 4'hF;
            dp         <= 1'b0;
            dig_sel    <= RST_SEL;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            act_val    <= act_val_nxt;
            act_dp     <= act_dp_nxt;
            frame_done <= swap;
            if (boundary) begin
                pending <= 1'b0;
            end else if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pending  <= 1'b1;
            end
            hex        <= hex_nxt;
            dp         <= dp_nxt;
            dig_sel    <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: directed scenarios plus random traffic against a frame-level reference model.
module tb_sseg_scan_driver;

    localparam int D     = 4;
    localparam int P     = 4;
    localparam int G     = 1;
    localparam int FRAME = D * P;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [4*D-1:0] value = '0;
    logic [D-1:0]  dp_in = '0;
    logic          lz_blank = 1'b0;
    logic [3:0]    hex;
    logic [D-1:0]  dig_sel;
    logic          dp;
    logic          pending;
    logic          frame_done;

    sseg_scan_driver #(.DIGITS(D), .PRESCALE(P), .GUARD(G)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
        .lz_blank(lz_blank), .hex(hex), .dig_sel(dig_sel), .dp(dp),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;

    // Reference model: time since reset plus the two buffers.
    bit             m_valid = 0;
    int             m_t = 0;
    logic [4*D-1:0] m_act, m_pend;
    logic [D-1:0]   m_dpm, m_pdp;
    bit             m_pending, m_fd, m_lz;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_hex(input int i);
        logic [4*D-1:0] sh;
        sh = m_act >> (4 * i);
        if (m_lz && i >= 1 && sh == '0)
            return 4'hF;
        return sh[3:0];
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_valid = 1; m_t = 0;
            m_act = {D{4'hF}}; m_dpm = '0; m_pend = '0; m_pdp = '0;
            m_pending = 0; m_fd = 0; m_lz = lz_blank;
        end else if (m_valid) begin
            m_fd = 0;
            if (m_t % FRAME == FRAME - 1) begin
                if (load) begin
                    m_act = value; m_dpm = dp_in; m_fd = 1;
                end else if (m_pending) begin
                    m_act = m_pend; m_dpm = m_pdp; m_fd = 1;
                end
                m_pending = 0;
            end else if (load) begin
                m_pend = value; m_pdp = dp_in; m_pending = 1;
            end
            m_t++;
            m_lz = lz_blank;
        end
    endtask

    task automatic step();
        int c, i;
        @(posedge clk);
        model_edge();
        #1;
        if (m_valid) begin
            c = m_t % P;
            i = (m_t / P) % D;
            check_eq("hex", 32'(hex), 32'(ref_hex(i)));
            check_eq("dig_sel", 32'(dig_sel), (c < G) ? 32'd0 : (32'd1 << i));
            check_eq("dp", 32'(dp), 32'(m_dpm[i]));
            check_eq("pending", 32'(pending), 32'(m_pending));
            check_eq("frame_done", 32'(frame_done), 32'(m_fd));
            if (frame_done === 1'b1) fd_cnt++;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_to(input int phase);
        for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != phase; k++) step();
        if ((m_t % FRAME) != phase) check_eq("run_to_timeout", 32'(m_t % FRAME), 32'(phase));
    endtask

    task automatic do_load(input logic [4*D-1:0] v, input logic [D-1:0] d);
        value = v; dp_in = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_v;
        // Reset and first frame
        run(3);
        check_eq("rst_hex", 32'(hex), 32'hF);
        check_eq("rst_sel", 32'(dig_sel), 32'd0);
        check_eq("rst_pend", 32'(pending), 32'd0);
        reset = 1'b0;
        step();
        check_eq("first_sel", 32'(dig_sel), 32'b0001);
        run(20);

        // Mid-frame load waits for the boundary
        run_to(5);
        fd_cnt = 0;
        do_load(16'h1234, 4'b0100);
        check_eq("pend_set", 32'(pending), 32'd1);
        for (int k = 0; k < 2 * FRAME && frame_done !== 1'b1; k++) step();
        check_eq("swap_seen", 32'(frame_done), 32'd1);
        exp_v = 16'h1234;
        for (int k = 0; k < FRAME; k++) begin
            if (k % P == 1) begin
                check_eq("scan_hex", 32'(hex), 32'(exp_v[4*(k/P) +: 4]));
                check_eq("scan_dp", 32'(dp), 32'((k / P) == 2));
            end
            step();
        end
        check_eq("fd_once", 32'(fd_cnt), 32'd1);

        // Leading-zero blanking
        lz_blank = 1'b1;
        do_load(16'h0050, 4'b0000);
        run(2 * FRAME + 4);
        do_load(16'h0000, 4'b0001);
        run(2 * FRAME + 4);
        lz_blank = 1'b0;

        // Two loads in one frame: last wins
        run_to(0);
        fd_cnt = 0;
        do_load(16'h1111, 4'b0000);
        run_to(9);
        do_load(16'h2222, 4'b0011);
        run(2 * FRAME);
        check_eq("fd_two_loads", 32'(fd_cnt), 32'd1);

        // Load exactly on the boundary overrides pending
        run_to(3);
        do_load(16'h1111, 4'b1000);
        run_to(FRAME - 1);
        do_load(16'hABCD, 4'b0001);
        check_eq("bnd_pend", 32'(pending), 32'd0);
        check_eq("bnd_fd", 32'(frame_done), 32'd1);
        check_eq("bnd_hex", 32'(hex), 32'hD);
        run(FRAME);

        // Reset mid-dwell with data pending
        run_to(4);
        do_load(16'h9876, 4'b1111);
        run_to(9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mid_rst_hex", 32'(hex), 32'hF);
        check_eq("mid_rst_pend", 32'(pending), 32'd0);
        check_eq("mid_rst_sel", 32'(dig_sel), 32'd0);
        run(FRAME + 2);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            load     = ($urandom_range(0, 7) == 0);
            value    = ($urandom_range(0, 3) == 0) ? 16'(16'h000F & $urandom) : 16'($urandom);
            dp_in    = 4'($urandom);
            if ($urandom_range(0, 31) == 0) lz_blank = ~lz_blank;
            reset    = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; load = 1'b0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Time-multiplexed scan controller for the scale's multi-digit 7-segment display.
- Sits directly upstream of the hex-to-segment decoder: presents one 4-bit digit code per dwell period, plus a one-hot digit select and a decimal point.
- Double-buffers the displayed value so a new reading never tears mid-frame.
- Applies leading-zero blanking by substituting code 4'hF, which the decoder renders as all segments off.

Parameters:
- DIGITS, 4, number of display digits; digit 0 is the rightmost, least significant digit.
- PRESCALE, 50000, clk cycles each digit is active (dwell). Legal range ≥ 4.
- GUARD, 2, cycles at the start of each dwell during which dig_sel is forced to all-zero (anti-ghosting). Legal range 0 ≤ GUARD < PRESCALE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe: capture value and dp_in into the pending buffer.
- value  in  4*DIGITS  digit codes; nibble i drives digit i.
- dp_in  in  DIGITS  decimal-point mask; bit i lights the dp of digit i.
- lz_blank  in  1  when 1, leading-zero blanking is enabled.
- hex  out  4  code for the current digit; feeds the decoder's hex input.
- dig_sel  out  DIGITS  one-hot, active-high digit enable.
- dp  out  1  decimal point for the current digit.
- pending  out  1  high while a loaded value is waiting for the frame boundary.
- frame_done  out  1  one-cycle pulse on the cycle the active buffer is updated.

Behaviour:
- Reset (synchronous, checked before everything else):
  - Prescaler and digit index cleared to 0.
  - Active buffer set to all 4'hF with dp mask 0; pending buffer cleared.
  - hex=4'hF, dp=0, pending=0, frame_done=0.
  - dig_sel=0 if GUARD>0, otherwise one-hot digit 0.
- Reset mid-frame discards both the pending and the active data.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - tick is asserted on the cycle the count equals PRESCALE-1.
- Digit index:
  - On tick, the index advances 0→1→…→DIGITS-1→0 (wraps).
- Frame boundary: tick while index==DIGITS-1. On that cycle:
  - If load=1, the active buffer takes value/dp_in directly.
  - Otherwise, if pending=1, the active buffer takes the pending buffer contents.
  - pending is cleared.
  - frame_done=1 for one cycle, only if the active buffer was actually written.
- load outside the boundary cycle:
  - Capture into the pending buffer and set pending=1 on the next edge.
  - A repeated load overwrites the pending buffer (last load wins).
- Leading-zero blanking (lz_blank=1): digit i (i≥1) is shown as 4'hF when its active nibble and every more-significant active nibble are all 4'h0. Digit 0 is never blanked. lz_blank is evaluated live, not buffered.
- dp for digit i = active dp mask bit i, independent of blanking.
- Output registers and timing:
  - hex, dp and dig_sel are registered, and hold stable for the whole dwell of the current index.
  - They reflect the new index, and the new active buffer when it swaps, starting on the cycle after the tick edge.
  - Latency from tick to updated outputs: 1 clk.
- Guard interval:
  - For the first GUARD cycles of each dwell (prescaler count 0..GUARD-1), dig_sel=0; for the rest of the dwell, dig_sel=one-hot(index).
  - hex and dp are already valid during the guard cycles.
- Width rule: the index register is ceil(log2(DIGITS)) bits wide, minimum 1. The prescaler register is wide enough to hold PRESCALE-1.
- Codes 4'hA–4'hF are passed through unaltered; only zero-blanking substitutes any code.

Test Plan (DIGITS=4, PRESCALE=4, GUARD=1):
- Reset 3 cycles, release → hex=F, dig_sel=0000 on count 0, then 0001 on counts 1–3; the next dwell shows 0010; a full frame takes 16 cycles.
- load value=16'h1234, dp_in=4'b0100, mid-frame → pending=1; outputs stay blank until the boundary, then frame_done pulses once. The next frame shows hex 4,3,2,1 on dig_sel 0001,0010,0100,1000, with dp=1 only on digit 2.
- lz_blank=1, value=16'h0050 → digits 3,2 show F, digit 1 shows 5, digit 0 shows 0. With value=16'h0000, only digit 0 shows 0; all others show F.
- Two loads in one frame (16'h1111 then 16'h2222) → only 2222 is ever displayed; frame_done pulses once.
- load asserted exactly on the boundary cycle with value=16'hABCD while pending holds 16'h1111 → the active buffer becomes ABCD, pending=0, and 1111 is never displayed.
- Assert reset at index 2 mid-dwell with data pending → outputs return to reset values the next cycle, pending=0, and the next frame is blank.
